// File: rtl/jpeg_rle_pkg.sv
// rtl/jpeg_rle_pkg.sv - shared types and constants for the rz1 zero-run stage
package jpeg_rle_pkg;

    localparam int unsigned DW_DEF = 12;
    localparam int unsigned SW_DEF = 4;

    // Zero-run lengths carried by the two special symbols (size is 0 for both)
    localparam logic [3:0] SYM_ZRL = 4'd15;
    localparam logic [3:0] SYM_EOB = 4'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_AC   = 1'b1
    } rle_state_t;

    typedef struct packed {
        logic [3:0]        rlen;
        logic [SW_DEF-1:0] size;
        logic [DW_DEF-1:0] amp;
        logic              dc;
        logic              eob;
    } rle_sym_t;

    // Size category of a DW_DEF-bit coefficient: smallest s with |x| < 2^s
    function automatic logic [SW_DEF-1:0] size_cat(input logic signed [DW_DEF-1:0] x);
        int a;
        a = (x < 0) ? -int'(x) : int'(x);
        size_cat = '0;
        for (int s = 0; s < int'(DW_DEF); s++) begin
            if (a >= (1 << s)) size_cat = SW_DEF'(s + 1);
        end
    endfunction

endpackage

// File: rtl/jpeg_rle_zero_run_if.sv
// rtl/jpeg_rle_zero_run_if.sv - coefficient-in / symbol-out bus of the rz1 stage
interface jpeg_rle_zero_run_if #(
    parameter int DW = 12,
    parameter int SW = 4
);
    logic          ena;
    logic          dstrb;
    logic [DW-1:0] din;
    logic [3:0]    rlen;
    logic [SW-1:0] size;
    logic [DW-1:0] amp;
    logic          den;
    logic          dc;
    logic          eob;

    modport master (
        output ena, dstrb, din,
        input  rlen, size, amp, den, dc, eob
    );

    modport slave (
        input  ena, dstrb, din,
        output rlen, size, amp, den, dc, eob
    );
endinterface

// File: rtl/jpeg_rle_size_cat.sv
// rtl/jpeg_rle_size_cat.sv - combinational JPEG size category and amplitude bits
module jpeg_rle_size_cat #(
    parameter int DW = 12,
    parameter int SW = 4
) (
    input  logic [DW-1:0] x_i,
    output logic [SW-1:0] size_o,
    output logic [DW-1:0] amp_o
);
    logic [DW-1:0] mag;
    logic [DW-1:0] xm1;
    logic [SW-1:0] sz;

    // Magnitude as unsigned DW bits (the most negative value maps to 2^(DW-1)),
    // size = position of the highest set magnitude bit + 1, amp = x or x-1
    // truncated to the low size bits.
    always_comb begin
        mag = x_i[DW-1] ? (~x_i + DW'(1)) : x_i;
        xm1 = x_i - DW'(1);
        sz  = '0;
        for (int s = 0; s < DW; s++) begin
            if (mag[s]) sz = SW'(s + 1);
        end
        amp_o = '0;
        for (int i = 0; i < DW; i++) begin
            if (i < int'(sz)) amp_o[i] = x_i[DW-1] ? xm1[i] : x_i[i];
        end
        size_o = sz;
    end
endmodule

// File: rtl/jpeg_rle_zero_run.sv
// rtl/jpeg_rle_zero_run.sv - rz1: coefficients to (run, size, amplitude) symbols
module jpeg_rle_zero_run
    import jpeg_rle_pkg::*;
#(
    parameter int DW   = 12,
    parameter int SW   = 4,
    parameter int BLKN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    jpeg_rle_zero_run_if.slave   bus
);
    localparam int IW = $clog2(BLKN);

    rle_state_t    state_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    zcnt_q;
    logic [3:0]    rlen_q;
    logic [SW-1:0] size_q;
    logic [DW-1:0] amp_q;
    logic          den_q;
    logic          dc_q;
    logic          eob_q;

    logic [SW-1:0] size_d;
    logic [DW-1:0] amp_d;
    logic          nz_d;
    logic          last_d;

    jpeg_rle_size_cat #(
        .DW (DW),
        .SW (SW)
    ) u_size_cat (
        .x_i    (bus.din),
        .size_o (size_d),
        .amp_o  (amp_d)
    );

    assign nz_d   = (bus.din != '0);
    assign last_d = (idx_q == IW'(BLKN - 1));

    // Block FSM with registered symbol outputs; ena=0 freezes everything,
    // so a pending den pulse is held rather than dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            zcnt_q  <= '0;
            rlen_q  <= '0;
            size_q  <= '0;
            amp_q   <= '0;
            den_q   <= 1'b0;
            dc_q    <= 1'b0;
            eob_q   <= 1'b0;
        end else if (bus.ena) begin
            rlen_q <= '0;
            size_q <= '0;
            amp_q  <= '0;
            den_q  <= 1'b0;
            dc_q   <= 1'b0;
            eob_q  <= 1'b0;
            if (bus.dstrb) begin
                // New block: any unfinished run of the previous block is discarded
                size_q  <= size_d;
                amp_q   <= amp_d;
                den_q   <= 1'b1;
                dc_q    <= 1'b1;
                idx_q   <= IW'(1);
                zcnt_q  <= '0;
                state_q <= ST_AC;
            end else if (state_q == ST_AC) begin
                if (nz_d) begin
                    rlen_q <= zcnt_q;
                    size_q <= size_d;
                    amp_q  <= amp_d;
                    den_q  <= 1'b1;
                    zcnt_q <= '0;
                end else if (last_d) begin
                    rlen_q <= SYM_EOB;
                    den_q  <= 1'b1;
                    eob_q  <= 1'b1;
                    zcnt_q <= '0;
                end else if (zcnt_q == 4'd15) begin
                    rlen_q <= SYM_ZRL;
                    den_q  <= 1'b1;
                    zcnt_q <= '0;
                end else begin
                    zcnt_q <= zcnt_q + 4'd1;
                end
                if (last_d) begin
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

    assign bus.rlen = rlen_q;
    assign bus.size = size_q;
    assign bus.amp  = amp_q;
    assign bus.den  = den_q;
    assign bus.dc   = dc_q;
    assign bus.eob  = eob_q;
endmodule

// File: tb/tb_jpeg_rle_zero_run.sv
// tb/tb_jpeg_rle_zero_run.sv - self-checking bench for jpeg_rle_zero_run
module tb_jpeg_rle_zero_run;
    localparam int DW = 12;
    localparam int SW = 4;

    typedef struct {
        int rlen;
        int size;
        int amp;
        bit dc;
        bit eob;
    } tsym_t;

    typedef struct {
        int din;
        int size;
        int amp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_e;
    int   checks = 0;
    int   errors = 0;
    tsym_t got_q[$];
    tsym_t exp_q[$];

    jpeg_rle_zero_run_if #(.DW(DW), .SW(SW)) bus ();

    jpeg_rle_zero_run #(.DW(DW), .SW(SW), .BLKN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Collect every symbol produced at an enabled edge
    always @(posedge clk) begin
        mon_e = bus.ena;
        #1;
        if (!rst && mon_e && bus.den)
            got_q.push_back('{int'(bus.rlen), int'(bus.size), int'(bus.amp), bus.dc, bus.eob});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_size(input int x);
        int a;
        int s;
        a = (x < 0) ? -x : x;
        s = 0;
        while (a >= (1 << s)) s++;
        return s;
    endfunction

    function automatic int ref_amp(input int x);
        if (x >= 0) return x;
        return (x - 1) & ((1 << ref_size(x)) - 1);
    endfunction

    function automatic void push_exp(input int r, input int s, input int a, input bit d, input bit e);
        exp_q.push_back('{r, s, a, d, e});
    endfunction

    // Symbols for the first n samples of block c (n < 64 means aborted by a new dstrb)
    function automatic void model_block(input int c[64], input int n);
        int z;
        push_exp(0, ref_size(c[0]), ref_amp(c[0]), 1'b1, 1'b0);
        z = 0;
        for (int i = 1; i < n; i++) begin
            if (c[i] != 0) begin
                for (int k = 0; k < z / 16; k++) push_exp(15, 0, 0, 1'b0, 1'b0);
                push_exp(z % 16, ref_size(c[i]), ref_amp(c[i]), 1'b0, 1'b0);
                z = 0;
            end else begin
                z++;
            end
        end
        if (n == 64 && c[63] == 0) begin
            for (int k = 0; k < (z - 1) / 16; k++) push_exp(15, 0, 0, 1'b0, 1'b0);
            push_exp(0, 0, 0, 1'b0, 1'b1);
        end else if (n < 64) begin
            for (int k = 0; k < z / 16; k++) push_exp(15, 0, 0, 1'b0, 1'b0);
        end
    endfunction

    task automatic feed(input int c[64], input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            while (rnd && $urandom_range(0, 2) == 0) begin
                bus.ena   = 1'b0;
                bus.dstrb = 1'($urandom_range(0, 1));
                bus.din   = DW'($urandom);
                @(negedge clk);
            end
            bus.ena   = 1'b1;
            bus.dstrb = (i == 0);
            bus.din   = c[i][DW-1:0];
            @(negedge clk);
        end
        bus.ena   = 1'b0;
        bus.dstrb = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.ena   = 1'($urandom_range(0, 1));
            bus.dstrb = 1'b0;
            bus.din   = DW'($urandom);
            @(negedge clk);
        end
        bus.ena = 1'b0;
    endtask

    task automatic compare_stream(input string name);
        int n;
        chk({name, " symbol count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL %s sym %0d: got r%0d s%0d a%0d dc%0d eob%0d expected r%0d s%0d a%0d dc%0d eob%0d",
                         name, i, got_q[i].rlen, got_q[i].size, got_q[i].amp, got_q[i].dc, got_q[i].eob,
                         exp_q[i].rlen, exp_q[i].size, exp_q[i].amp, exp_q[i].dc, exp_q[i].eob);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, " rlen"}, int'(bus.rlen), 0);
        chk({name, " size"}, int'(bus.size), 0);
        chk({name, " amp"},  int'(bus.amp),  0);
        chk({name, " den"},  int'(bus.den),  0);
        chk({name, " dc"},   int'(bus.dc),   0);
        chk({name, " eob"},  int'(bus.eob),  0);
    endtask

    initial begin
        vec_t vt[12];
        int   c[64];
        int   n;

        vt = '{'{0, 0, 0}, '{1, 1, 1}, '{-1, 1, 0}, '{5, 3, 5}, '{-3, 2, 0}, '{7, 3, 7},
               '{-4, 3, 3}, '{2047, 11, 2047}, '{-2048, 12, 2047}, '{-2047, 11, 0},
               '{1024, 11, 1024}, '{-1024, 11, 1023}};

        bus.ena   = 1'b0;
        bus.dstrb = 1'b0;
        bus.din   = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        bus.ena = 1'b1;
        bus.din = 12'd9;
        @(negedge clk);
        chk_outputs_zero("idle ignores din");

        // DC size/amplitude table
        foreach (vt[i]) begin
            bus.ena   = 1'b1;
            bus.dstrb = 1'b1;
            bus.din   = vt[i].din[DW-1:0];
            @(posedge clk);
            #1;
            chk($sformatf("table %0d den", vt[i].din), int'(bus.den), 1);
            chk($sformatf("table %0d dc", vt[i].din), int'(bus.dc), 1);
            chk($sformatf("table %0d size", vt[i].din), int'(bus.size), vt[i].size);
            chk($sformatf("table %0d amp", vt[i].din), int'(bus.amp), vt[i].amp);
            @(negedge clk);
        end

        // ena=0 holds the den pulse and the tuple
        bus.ena   = 1'b1;
        bus.dstrb = 1'b1;
        bus.din   = 12'd5;
        @(negedge clk);
        bus.ena = 1'b0;
        bus.din = 12'd100;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("hold den", int'(bus.den), 1);
            chk("hold amp", int'(bus.amp), 5);
        end
        @(negedge clk);
        bus.ena   = 1'b1;
        bus.dstrb = 1'b0;
        bus.din   = '0;
        @(posedge clk);
        #1;
        chk("first ac zero den", int'(bus.den), 0);
        @(negedge clk);
        bus.ena = 1'b0;
        @(negedge clk);
        got_q.delete();

        // DC 5 then 63 zeros
        c = '{default: 0};
        c[0] = 5;
        feed(c, 64, 1'b0);
        idle(3);
        chk("seq1 first size", got_q.size() > 0 ? got_q[0].size : -1, 3);
        chk("seq1 den count", got_q.size(), 5);
        model_block(c, 64);
        compare_stream("seq1");

        // DC -3, AC 0,0,7
        c = '{default: 0};
        c[0] = -3;
        c[3] = 7;
        feed(c, 64, 1'b0);
        idle(3);
        chk("seq2 ac rlen", got_q.size() > 1 ? got_q[1].rlen : -1, 2);
        model_block(c, 64);
        compare_stream("seq2");

        // DC 0, 20 zeros then -1
        c = '{default: 0};
        c[21] = -1;
        feed(c, 64, 1'b0);
        idle(3);
        chk("seq3 rlen after zrl", got_q.size() > 2 ? got_q[2].rlen : -1, 4);
        model_block(c, 64);
        compare_stream("seq3");

        // 62 zeros then a last AC of 1: block full, no EOB
        c = '{default: 0};
        c[0]  = 2;
        c[63] = 1;
        feed(c, 64, 1'b0);
        idle(3);
        chk("seq4 den count", got_q.size(), 5);
        chk("seq4 last eob", got_q.size() > 0 ? int'(got_q[got_q.size()-1].eob) : -1, 0);
        chk("seq4 last rlen", got_q.size() > 0 ? got_q[got_q.size()-1].rlen : -1, 14);
        model_block(c, 64);
        compare_stream("seq4");

        // Abort at idx 30 inside a zero run; zcnt must restart
        c = '{default: 0};
        c[0] = 8;
        feed(c, 30, 1'b0);
        model_block(c, 30);
        c = '{default: 0};
        c[0]  = 9;
        c[15] = 3;
        feed(c, 64, 1'b0);
        idle(3);
        model_block(c, 64);
        compare_stream("abort");

        // Random blocks, random ena gaps, some aborts, garbage while idle
        for (int b = 0; b < 24; b++) begin
            c = '{default: 0};
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 4 + (b % 3) * 8) == 0)
                    c[i] = int'($urandom_range(0, 4095)) - 2048;
            end
            if (b % 5 == 1) c[63] = int'($urandom_range(1, 50));
            n = (b % 4 == 2) ? int'($urandom_range(1, 63)) : 64;
            feed(c, n, 1'b1);
            model_block(c, n);
            if (n == 64) idle(int'($urandom_range(0, 4)));
        end
        idle(3);
        compare_stream("random");

        // Asynchronous reset in the middle of a block
        c = '{default: 0};
        c[0]  = 4;
        c[19] = 6;
        feed(c, 20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            bus.ena   = 1'b1;
            bus.dstrb = 1'b0;
            bus.din   = 12'(i + 1);
            @(negedge clk);
        end
        bus.ena = 1'b0;
        chk("idle after reset", got_q.size(), 0);
        got_q.delete();
        c = '{default: 0};
        c[0]  = -7;
        c[40] = 12;
        feed(c, 64, 1'b1);
        idle(3);
        model_block(c, 64);
        compare_stream("post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
